// File: rtl/mode_req_arbiter.sv
// Round-robin arbiter guarding a 2-bit operating-mode register with a legal-transition table and per-requester lockout.
// Optional build macro MODE_ALARM_EN adds a sticky alarm output that also forces the mode to SAFE.
module mode_req_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int LOCK_THRESH = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [3*NUM_REQ-1:0]   req_mode,
    output logic [NUM_REQ-1:0]     ack,
    output logic                   err,
    output logic [NUM_REQ-1:0]     locked,
    output logic [1:0]             mode,
    output logic                   busy,
`ifdef MODE_ALARM_EN
    output logic                   alarm,
`endif
    output logic [1:0]             state_dbg
);

    // Handshake: req[i] and its req_mode slice are level-held until ack[i] pulses
    // for one cycle; the requester drops req the cycle after ack, otherwise a new
    // request is seen when the arbiter returns to IDLE.

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_CHECK = 2'b01;
    localparam logic [1:0] ST_RESP  = 2'b10;
    localparam logic [1:0] ST_BAD   = 2'b11;

    localparam logic [3:0]     THRESH    = 4'(LOCK_THRESH);
    localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);

    logic [1:0]         state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   ptr_next;
    logic [IDX_W-1:0]   win_idx;
    logic [2:0]         win_code;
    logic [3:0]         rej_cnt [NUM_REQ];

    logic [NUM_REQ-1:0] valid;
    logic [NUM_REQ-1:0] rot;
    logic [IDX_W-1:0]   pick_off;
    logic [IDX_W:0]     pick_sum;
    logic [IDX_W-1:0]   pick_idx;
    logic [2:0]         pick_code;
    logic               pick_found;

    logic               legal;
    logic [3:0]         sel_cnt;
    logic [3:0]         cnt_inc;
    logic               lock_now;
    logic [NUM_REQ-1:0] win_onehot;

    // Only four (current, target) pairs within 0..3 are illegal; codes 4..7 never are legal.
    function automatic logic is_legal(input logic [2:0] code, input logic [1:0] cur);
        logic ok;
        if (code[2]) begin
            ok = 1'b0;
        end else begin
            case ({cur, code[1:0]})
                4'b00_10, 4'b00_11, 4'b01_11, 4'b11_01: ok = 1'b0;
                default:                                 ok = 1'b1;
            endcase
        end
        return ok;
    endfunction

    assign valid     = req & ~locked;
    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;
    assign legal     = is_legal(win_code, mode);

    always_comb begin
        rot        = NUM_REQ'({valid, valid} >> ptr);
        pick_found = 1'b0;
        pick_off   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pick_found && rot[i]) begin
                pick_found = 1'b1;
                pick_off   = IDX_W'(i);
            end
        end
        pick_sum = {1'b0, ptr} + {1'b0, pick_off};
        if (pick_sum >= NUM_REQ_W) begin
            pick_sum = pick_sum - NUM_REQ_W;
        end
        pick_idx  = pick_sum[IDX_W-1:0];
        pick_code = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                pick_code = req_mode[3*i +: 3];
            end
        end
    end

    always_comb begin
        sel_cnt    = '0;
        win_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IDX_W'(i)) begin
                sel_cnt       = rej_cnt[i];
                win_onehot[i] = 1'b1;
            end
        end
        cnt_inc  = (sel_cnt < THRESH) ? sel_cnt + 4'd1 : sel_cnt;
        lock_now = !legal && (cnt_inc == THRESH);
        if (win_idx == IDX_W'(NUM_REQ - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = win_idx + IDX_W'(1);
        end
    end

`ifdef MODE_ALARM_EN
    logic alarm_evt;
    assign alarm_evt = (state == ST_BAD) || ((state == ST_CHECK) && lock_now);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            mode     <= 2'b00;
            ack      <= '0;
            err      <= 1'b0;
            locked   <= '0;
            ptr      <= '0;
            win_idx  <= '0;
            win_code <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                rej_cnt[i] <= '0;
            end
`ifdef MODE_ALARM_EN
            alarm    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    ack <= '0;
                    err <= 1'b0;
                    if (pick_found) begin
                        win_idx  <= pick_idx;
                        win_code <= pick_code;
                        state    <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    state <= ST_RESP;
                    ack   <= win_onehot;
                    err   <= !legal;
                    ptr   <= ptr_next;
                    if (legal) begin
                        mode <= win_code[1:0];
                    end
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (win_onehot[i]) begin
                            rej_cnt[i] <= legal ? 4'd0 : cnt_inc;
                            if (lock_now) begin
                                locked[i] <= 1'b1;
                            end
                        end
                    end
                end
                ST_RESP: begin
                    ack   <= '0;
                    err   <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    ack   <= '0;
                    err   <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
`ifdef MODE_ALARM_EN
            if (alarm_evt) begin
                alarm <= 1'b1;
                mode  <= 2'b00;
            end
`endif
        end
    end

endmodule

// File: tb/tb_mode_req_arbiter.sv
// Bench for mode_req_arbiter: directed scenarios plus randomized rounds against a transaction-level model.
// Alarm checks are compiled only when MODE_ALARM_EN is defined.
module tb_mode_req_arbiter;
    localparam int NUM_REQ     = 4;
    localparam int LOCK_THRESH = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_REQ-1:0]   req;
    logic [3*NUM_REQ-1:0] req_mode;
    logic [NUM_REQ-1:0]   ack;
    logic                 err;
    logic [NUM_REQ-1:0]   locked;
    logic [1:0]           mode;
    logic                 busy;
    logic [1:0]           state_dbg;
`ifdef MODE_ALARM_EN
    logic                 alarm;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: mode register, reject counts, locks, round-robin pointer.
    int m_mode;
    int m_ptr;
    int m_cnt [NUM_REQ];
    bit m_locked [NUM_REQ];
    bit m_alarm;

    mode_req_arbiter #(.NUM_REQ(NUM_REQ), .LOCK_THRESH(LOCK_THRESH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_mode  (req_mode),
        .ack       (ack),
        .err       (err),
        .locked    (locked),
        .mode      (mode),
        .busy      (busy),
`ifdef MODE_ALARM_EN
        .alarm     (alarm),
`endif
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NUM_REQ-1:0] model_locked_vec();
        logic [NUM_REQ-1:0] v;
        for (int i = 0; i < NUM_REQ; i++) v[i] = m_locked[i];
        return v;
    endfunction

    function automatic bit model_legal(input int t, input int m);
        if (t >= 4) return 1'b0;
        if (t == 0) return 1'b1;
        if (t == m) return 1'b1;
        if (t - m == 1 || m - t == 1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int model_pick();
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NUM_REQ;
            if (req[idx] && !m_locked[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_ptr   = 0;
        m_alarm = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            m_cnt[i]    = 0;
            m_locked[i] = 1'b0;
        end
    endtask

    task automatic set_req(input int i, input int code);
        req[i]            = 1'b1;
        req_mode[3*i +: 3] = 3'(code);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        req      = '0;
        req_mode = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("reset_ack", ack, 0);
        chk("reset_err", err, 0);
        chk("reset_locked", locked, 0);
        chk("reset_mode", mode, 0);
        chk("reset_busy", busy, 0);
        chk("reset_state", state_dbg, 0);
`ifdef MODE_ALARM_EN
        chk("reset_alarm", alarm, 0);
`endif
        rst = 1'b0;
    endtask

    // Called #1 after an edge with the arbiter idle and requests already driven.
    task automatic serve_one(input bit drop_early, output int w);
        int t;
        bit ok;
        w = model_pick();
        if (w < 0) return;
        t = int'(req_mode[3*w +: 3]);
        @(posedge clk); #1;
        if (drop_early) req[w] = 1'b0;
        chk("check_busy", busy, 1);
        chk("check_ack", ack, 0);
        @(posedge clk); #1;
        ok = model_legal(t, m_mode);
        if (ok) begin
            m_mode   = t;
            m_cnt[w] = 0;
        end else begin
            if (m_cnt[w] < LOCK_THRESH) m_cnt[w]++;
            if (m_cnt[w] == LOCK_THRESH && !m_locked[w]) begin
                m_locked[w] = 1'b1;
`ifdef MODE_ALARM_EN
                m_alarm = 1'b1;
                m_mode  = 0;
`endif
            end
        end
        m_ptr = (w + 1) % NUM_REQ;
        chk("resp_ack", ack, 1 << w);
        chk("resp_err", err, !ok);
        chk("resp_mode", mode, m_mode);
        chk("resp_locked", locked, model_locked_vec());
        chk("resp_busy", busy, 1);
`ifdef MODE_ALARM_EN
        chk("resp_alarm", alarm, m_alarm);
`endif
        req[w] = 1'b0;
        @(posedge clk); #1;
        chk("post_ack", ack, 0);
        chk("post_err", err, 0);
        chk("post_busy", busy, 0);
    endtask

    task automatic check_idle(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            chk("idle_ack", ack, 0);
            chk("idle_busy", busy, 0);
            chk("idle_mode", mode, m_mode);
        end
    endtask

    task automatic serve_single(input int i, input int code);
        int w;
        set_req(i, code);
        serve_one(1'b0, w);
        chk("single_winner", w, i);
    endtask

    initial begin
        int w;
        int code;
        int r;
        logic [NUM_REQ-1:0] rv;

        rst      = 1'b1;
        req      = '0;
        req_mode = '0;
        model_reset();

        // Basic latency from reset: SAFE -> LOW by requester 0.
        do_reset();
        set_req(0, 1);
        serve_one(1'b0, w);
        chk("t1_winner", w, 0);
        chk("t1_mode", mode, 1);

        // Four requesters at once from mode LOW, pointer at 0.
        do_reset();
        serve_single(3, 1);
        set_req(0, 2); set_req(1, 0); set_req(2, 1); set_req(3, 2);
        for (int k = 0; k < NUM_REQ; k++) begin
            serve_one(1'b0, w);
            chk("t2_order", w, k);
        end
        chk("t2_final_mode", mode, 2);

        // Lockout of requester 2 via SAFE -> HIGH.
        do_reset();
        for (int k = 0; k < LOCK_THRESH; k++) serve_single(2, 3);
        chk("t3_locked", locked, 4'b0100);
        set_req(2, 1);
        check_idle(6);
        req = '0;

        // Out-of-range codes, same-mode no-op clearing the counter.
        serve_single(0, 4);
        serve_single(1, 5);
        serve_single(3, 6);
        serve_single(0, 7);
        chk("t4_mode_safe", mode, 0);
        serve_single(1, 1);
        serve_single(1, 2);
        serve_single(0, 2);
        chk("t4_noop_mode", mode, 2);
        serve_single(0, 4);
        serve_single(0, 5);
        chk("t4_not_locked", locked[0], 0);

        // Dropping req during CHECK still completes the request.
        set_req(3, 3);
        serve_one(1'b1, w);
        chk("t_drop_winner", w, 3);

        // Reset during CHECK aborts the request and clears locks.
        do_reset();
        for (int k = 0; k < LOCK_THRESH; k++) serve_single(3, 2);
        serve_single(0, 1);
        serve_single(0, 2);
        set_req(0, 3);
        @(posedge clk); #1;
        chk("t5_busy", busy, 1);
        rst = 1'b1;
        req = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        chk("t5_ack", ack, 0);
        chk("t5_mode", mode, 0);
        chk("t5_locked", locked, 0);
        chk("t5_state", state_dbg, 0);
        check_idle(2);

`ifdef MODE_ALARM_EN
        // Illegal state encoding recovers and raises the alarm.
        serve_single(1, 1);
        force dut.state = 2'b11;
        #2;
        release dut.state;
        @(posedge clk); #1;
        chk("alarm_state", state_dbg, 0);
        chk("alarm_set", alarm, 1);
        chk("alarm_mode", mode, 0);
        chk("alarm_ack", ack, 0);
        do_reset();
        serve_single(1, 1);
        for (int k = 0; k < LOCK_THRESH; k++) serve_single(1, 3);
        chk("alarm_lock", alarm, 1);
        chk("alarm_lock_mode", mode, 0);
`endif

        // Randomized rounds against the model.
        for (int round = 0; round < 40; round++) begin
            if (round % 6 == 0) do_reset();
            rv = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            for (int i = 0; i < NUM_REQ; i++) begin
                if (rv[i]) begin
                    r = $urandom_range(0, 3);
                    case (r)
                        0:       code = $urandom_range(0, 7);
                        1:       code = m_mode;
                        2:       code = (m_mode < 3) ? m_mode + 1 : 0;
                        default: code = (m_mode > 0) ? m_mode - 1 : 2;
                    endcase
                    set_req(i, code);
                end
            end
            for (int k = 0; k < NUM_REQ; k++) begin
                if (model_pick() >= 0) serve_one(1'($urandom_range(0, 1)), w);
            end
            check_idle(2);
            req = '0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mode_req_arbiter.md
Name: mode_req_arbiter

Overview:
- Secure controller for a 2-bit operating-mode register: SAFE=0, LOW=1, MID=2, HIGH=3.
- Arbitrates mode-change requests from NUM_REQ requesters and validates each 3-bit requested code against a legal-transition table.
- Applies legal changes and rejects everything else.
- Fully specified FSM with no dead or unreachable states; every undefined encoding or input recovers to a defined state.
- Requesters that repeatedly submit illegal requests are locked out.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- LOCK_THRESH, 3, consecutive rejects from one requester before it is locked (1..15).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- req  input  NUM_REQ  per-requester request; held until ack.
- req_mode  input  3*NUM_REQ  requested mode code; requester i uses bits [3i+2:3i]; held with req.
- ack  output  NUM_REQ  one-hot, one-cycle completion pulse to the served requester.
- err  output  1  one-cycle pulse, coincident with ack, when the request was rejected.
- locked  output  NUM_REQ  sticky per-requester lockout flags.
- mode  output  2  current mode.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Clocking and reset:
  - Single clock.
  - Reset is synchronous and active-high.
  - On rst: mode=0 (SAFE), ack=0, err=0, locked=0, busy=0, FSM=IDLE, round-robin pointer=0, all reject counters=0.
  - rst asserted mid-operation aborts the operation; no ack is issued for it.
- FSM states:
  - IDLE: busy=0. Valid set = req & ~locked. If the valid set is non-empty, pick the first valid index at or after the pointer, wrapping. Latch the winner index and its req_mode, then go to CHECK. Otherwise stay in IDLE.
  - CHECK: busy=1. Evaluate legality of the latched code against the current mode, then go to RESP.
  - RESP: busy=1. ack[winner]=1 for exactly this cycle. mode and err are updated on the edge entering RESP. Pointer <= (winner+1) mod NUM_REQ. Next state is IDLE.
  - Encoding is 2-bit with one unused code. The unused code goes to IDLE on the next edge with no ack. mode is unchanged.
- Latency:
  - Request sampled in IDLE at edge T. CHECK runs during cycle T+1. ack/err/mode are visible in cycle T+2.
  - Back-to-back service is possible every 3 cycles.
- Legality, with code t and current mode m:
  - t >= 4: illegal.
  - t == 0: always legal (fall to SAFE).
  - t == m: legal no-op; ack with err=0, mode unchanged.
  - |t-m| == 1: legal.
  - Otherwise illegal. Example: SAFE->HIGH is illegal.
- Legal request: mode <= t, err=0, winner's reject counter cleared.
- Illegal request: mode unchanged, err=1, winner's counter increments (saturating at LOCK_THRESH). When the counter reaches LOCK_THRESH, locked[winner] <= 1 in the same RESP edge. Lock is sticky until rst.
- Boundary rules:
  - Requests arriving while busy wait; req is level-held.
  - req dropped during CHECK: latched values are still used and ack is still issued.
  - Locked requesters are never served and never acked.
  - All requesters locked: FSM idles permanently and mode holds.
  - Requester must deassert req in the cycle after ack. A req still high in IDLE is a new request.
  - NUM_REQ=1: the pointer is constant 0.

Optional Feature:
- Macro: MODE_ALARM_EN.
- Defined:
  - Adds output port alarm (1 bit). Reset value is 0.
  - alarm goes high, sticky until rst, on the edge after either of these: FSM register holds the unused encoding, or any locked bit sets.
  - In the same edge alarm sets, mode is forced to SAFE.
- Not defined:
  - No alarm port.
  - Unused FSM encoding silently recovers to IDLE.
  - Lockout does not affect mode.

Test Plan:
- Reset, then req[0]=1, req_mode0=1 sampled at edge T -> ack=4'b0001 in cycle T+2 only, mode=1, err=0, busy high in cycles T+1 and T+2.
- From mode=1, req[0]..req[3] all high with codes 2,0,1,2 -> served in order 0,1,2,3. Acks 3 cycles apart. Final mode=2 (1->2->0->1->2). No err.
- mode=0, req[2]=1, code=3 -> ack[2] and err=1, mode stays 0. Repeat twice more -> locked[2]=1 on the third RESP. A fourth req[2] is never acked and busy stays 0.
- Codes 4..7 from any mode -> err=1, mode unchanged. Code equal to current mode (2 at mode=2) -> ack, err=0, counter cleared.
- rst asserted during CHECK of a legal request to 3 from mode 2 -> no ack, mode=0, locked=0, FSM=IDLE on the next cycle.
- MODE_ALARM_EN defined: force the FSM register to the unused code -> IDLE next cycle, alarm=1, mode=0. Separately, lock requester 1 -> alarm=1 and mode=0 on the same edge.
